// File: rtl/scoreboard_view.sv
// Answer-competition scoreboard view: 8-digit multiplexed tube, player LEDs, buzzer request.
// Optional build macro SCOREBOARD_TICK_BEEP_EN adds per-second beeps over the last five countdown seconds.
module scoreboard_view #(
  parameter int N_PLAYERS     = 4,
  parameter int SCORE_W       = 7,
  parameter int SCROLL_CYCLES = 100_000_000,
  parameter int BLINK_CYCLES  = 25_000_000,
  parameter int BEEP_CYCLES   = 20_000_000,
  parameter int SCAN_CYCLES   = 100_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         view_en,
  input  logic [3:0]                   play_count,
  input  logic [2:0]                   state,
  input  logic [17:0]                  time_remain,
  input  logic [N_PLAYERS*SCORE_W-1:0] scores,
  input  logic [3:0]                   select_player,
  input  logic [3:0]                   winner,
  output logic [7:0]                   seg_out,
  output logic [7:0]                   seg_en,
  output logic [N_PLAYERS-1:0]         led,
  output logic                         beep
);

  localparam int SCROLL_W = $clog2(SCROLL_CYCLES + 1);
  localparam int BLINK_W  = $clog2(BLINK_CYCLES + 1);
  localparam int BEEP_W   = $clog2(BEEP_CYCLES + 1);
  localparam int SCAN_W   = $clog2(SCAN_CYCLES + 1);

  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_CYCLES - 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [BEEP_W-1:0]   BEEP_MAX    = BEEP_W'(BEEP_CYCLES);
  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [3:0]          N_P         = 4'(N_PLAYERS);

  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_DASH  = 8'hBF;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      4'd10:   glyph = 8'h88;
      4'd11:   glyph = 8'h83;
      4'd12:   glyph = 8'hC6;
      4'd13:   glyph = G_DASH;
      default: glyph = G_BLANK;
    endcase
  endfunction

  // Three glyphs {d5,d6,d7}, saturated at 999, leading zeros blanked but units always lit.
  function automatic logic [23:0] dec3(input logic [9:0] v);
    logic [9:0] s;
    logic [3:0] h, t, u;
    s = (v > 10'd999) ? 10'd999 : v;
    h = 4'(s / 10'd100);
    t = 4'((s / 10'd10) % 10'd10);
    u = 4'(s % 10'd10);
    dec3 = {(h != 4'd0) ? glyph(h) : G_BLANK,
            (h != 4'd0 || t != 4'd0) ? glyph(t) : G_BLANK,
            glyph(u)};
  endfunction

  function automatic logic [N_PLAYERS-1:0] onehot(input logic [3:0] n);
    for (int k = 0; k < N_PLAYERS; k++) onehot[k] = (n == 4'(k + 1));
  endfunction

  logic [7:0][7:0]         r_dig;
  logic [N_PLAYERS-1:0]    r_led;
  logic [7:0]              r_seg_out, r_seg_en;
  logic [2:0]              r_scan_idx;
  logic [SCAN_W-1:0]       r_scan_cnt;
  logic [SCROLL_W-1:0]     r_scroll_cnt;
  logic [3:0]              r_p;
  logic [BLINK_W-1:0]      r_blink_cnt;
  logic                    r_blink;
  logic [BEEP_W-1:0]       r_beep_cnt;
  logic [2:0]              r_last_state;

  logic [7:0][7:0]         w_dig;
  logic [N_PLAYERS-1:0]    w_led;
  logic                    w_autoscroll, w_valid_sel, w_win_valid;
  logic [3:0]              w_show_player;
  logic [9:0]              w_score;
  logic [17:0]             w_sec_full;
  logic [9:0]              w_sec;
  logic                    w_trig, w_tick;

  assign w_autoscroll  = (state == 3'd0) && (play_count != 4'd0) && (select_player == 4'd0);
  assign w_valid_sel   = (select_player != 4'd0) && (select_player <= N_P);
  assign w_win_valid   = (winner != 4'd0) && (winner <= N_P);
  assign w_show_player = w_autoscroll ? r_p : select_player;
  assign w_sec_full    = time_remain / 18'd1000;
  assign w_sec         = (w_sec_full > 18'd999) ? 10'd999 : w_sec_full[9:0];

  always_comb begin
    w_score = '0;
    for (int k = 0; k < N_PLAYERS; k++)
      if (w_show_player == 4'(k + 1)) w_score = 10'(scores[k*SCORE_W +: SCORE_W]);
  end

  always_comb begin
    w_dig    = {8{G_BLANK}};
    w_led    = '0;
    w_dig[0] = glyph(4'd12);
    w_dig[1] = (play_count > 4'd9) ? G_DASH : glyph(play_count);
    w_dig[2] = (state <= 3'd2) ? glyph({1'b0, state} + 4'd10) : G_DASH;
    case (state)
      3'd0: begin
        if (play_count != 4'd0) begin
          if (w_autoscroll || w_valid_sel) begin
            w_dig[4]                      = glyph(w_show_player);
            {w_dig[5], w_dig[6], w_dig[7]} = dec3(w_score);
            w_led                         = onehot(w_show_player);
          end else begin
            w_dig[4] = G_DASH;
          end
        end
      end
      3'd1: begin
        // Final seconds flash by blanking the number in the off phase.
        if (!(w_sec < 10'd5 && !r_blink))
          {w_dig[5], w_dig[6], w_dig[7]} = dec3(w_sec);
      end
      3'd2: begin
        if (w_win_valid) begin
          w_dig[4] = r_blink ? glyph(winner) : G_BLANK;
          w_led    = r_blink ? onehot(winner) : '0;
        end else begin
          w_dig[4] = G_DASH;
        end
      end
      default: ;
    endcase
  end

`ifdef SCOREBOARD_TICK_BEEP_EN
  logic [9:0] r_last_sec;
  always_ff @(posedge clk) begin
    if (rst) r_last_sec <= '0;
    else     r_last_sec <= w_sec;
  end
  assign w_tick = view_en && (state == 3'd1) && (r_last_state == 3'd1) &&
                  (w_sec < r_last_sec) && (w_sec >= 10'd1) && (w_sec <= 10'd5);
`else
  assign w_tick = 1'b0;
`endif

  assign w_trig = (view_en && (((r_last_state == 3'd0) && (state == 3'd1)) ||
                               ((r_last_state == 3'd1) && (state == 3'd2)))) || w_tick;

  // Free-running timebases: they keep counting while another view owns the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt   <= '0;
      r_scan_idx   <= '0;
      r_blink_cnt  <= '0;
      r_blink      <= 1'b1;
      r_scroll_cnt <= '0;
      r_p          <= 4'd1;
    end else begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_scan_idx <= r_scan_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
      if (!w_autoscroll) begin
        r_scroll_cnt <= '0;
        r_p          <= 4'd1;
      end else if (r_scroll_cnt == SCROLL_LAST) begin
        r_scroll_cnt <= '0;
        r_p          <= (r_p == N_P) ? 4'd1 : r_p + 4'd1;
      end else begin
        r_scroll_cnt <= r_scroll_cnt + SCROLL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beep_cnt   <= '0;
      r_last_state <= 3'd0;
    end else begin
      if (!view_en)                 r_beep_cnt <= '0;
      else if (w_trig)              r_beep_cnt <= BEEP_MAX;
      else if (r_beep_cnt != '0)    r_beep_cnt <= r_beep_cnt - BEEP_W'(1);
      if (view_en) r_last_state <= state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig     <= {8{G_BLANK}};
      r_led     <= '0;
      r_seg_out <= G_BLANK;
      r_seg_en  <= 8'hFF;
    end else begin
      r_dig     <= w_dig;
      r_led     <= view_en ? w_led : '0;
      r_seg_out <= view_en ? r_dig[r_scan_idx] : G_BLANK;
      r_seg_en  <= view_en ? ~(8'd1 << r_scan_idx) : 8'hFF;
    end
  end

  assign seg_out = r_seg_out;
  assign seg_en  = r_seg_en;
  assign led     = r_led;
  assign beep    = (r_beep_cnt != '0);

endmodule

// File: doc/scoreboard_view.md
# scoreboard_view

Parametrised display/alert controller for the answer-competition mode, driving the 8-digit multiplexed tube, the player LEDs and the buzzer-request line. It sits between the competition controller (state, countdown, per-player scores, selection, winner) and the board I/O. It generalises the fixed four-player view to N players and three-digit scores. It adds idle auto-scroll, countdown and winner blinking, and an integrated digit scanner.

## Interface
Parameters:
- N_PLAYERS, 4: player count, 2..8.
- SCORE_W, 7: bits per score, ≤10; displayed value saturates at 999.
- SCROLL_CYCLES, 100_000_000: dwell per player in auto-scroll.
- BLINK_CYCLES, 25_000_000: half-period of blink phase.
- BEEP_CYCLES, 20_000_000: buzzer-request pulse length.
- SCAN_CYCLES, 100_000: dwell per tube digit.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset. One clock; reset is synchronous and active-high.
- view_en, in, 1: this view owns the display.
- play_count, in, 4: rounds played.
- state, in, 3: 0 select, 1 countdown, 2 result, other = invalid.
- time_remain, in, 18: countdown in ms.
- scores, in, N_PLAYERS*SCORE_W: player k+1 at bits [k*SCORE_W +: SCORE_W].
- select_player, in, 4: 0 = none, 1..N valid, >N out-of-range.
- winner, in, 4: 0 = none, 1..N valid.
- seg_out, out, 8: active-low segments + dp.
- seg_en, out, 8: active-low one-hot digit enable.
- led, out, N_PLAYERS: player LEDs.
- beep, out, 1: buzzer request.

## Operation
- Glyphs (active-low): 0-9 = C0,F9,A4,B0,99,92,82,F8,80,90; A/B/C = 88,83,C6; '-' = BF; blank = FF.
- d0..d7 are left to right.
  - d0 = 'C'.
  - d1 = play_count; values >9 show '-'.
  - d2 = glyph(state+10) for states 0..2, else '-'.
  - d3 = blank.
- Number fields d5..d7: 3-digit decimal, leading-zero blanking; units always shown.
- State 0:
  - play_count==0: d4..d7 blank, led=0.
  - Else, select_player valid: d4 = player number, d5..d7 = score, led one-hot on that player.
  - Else, select_player==0: auto-scroll. Index p starts at 1 and advances every SCROLL_CYCLES, N wraps to 1. Displays p and p's score; led one-hot on p.
  - Else, select_player >N: d4 = '-', d5..d7 blank, led=0.
  - Leaving auto-scroll resets p=1 and clears the scroll counter.
- State 1:
  - sec = time_remain/1000, saturated at 999, shown in d5..d7; d4 blank; led=0.
  - While sec<5: d5..d7 blank during blink-off phase.
- State 2:
  - d4 = winner number ('-' if 0 or >N); d5..d7 blank.
  - Valid winner: d4 and led[winner-1] blink together.
- Invalid state: d3..d7 blank, led=0.
- Beep:
  - A 0→1 or 1→2 transition of state, compared with last_state, starts a BEEP_CYCLES pulse.
  - A new trigger during a pulse restarts the count.
  - last_state updates only while view_en=1.
- view_en=0:
  - seg_en=FF, seg_out=FF, led=0, beep forced 0 (counter cleared).
  - Scroll, blink and scan counters keep running.
- Scanner: digit index 0..7 advances every SCAN_CYCLES and wraps 7→0. seg_en = ~(1<<idx); seg_out = that digit's glyph.

## Timing
- Reset values:
  - seg_out=FF, seg_en=FF, led=0, beep=0.
  - All digit registers blank; last_state=0; p=1.
  - All counters 0; blink phase = on; scan idx=0.
- Digit registers and led are registered: inputs sampled at edge t are visible at t+1. seg_out reflects a digit when the scanner next selects it.
- Beep: transition sampled at edge t → beep=1 from t+1 for exactly BEEP_CYCLES cycles.
- Blink phase toggles every BLINK_CYCLES cycles. Scroll advances on the cycle the counter reaches SCROLL_CYCLES-1.
- rst mid-pulse or mid-scroll: all state returns to reset values on that edge.
- Score-to-decimal conversion completes within the registered cycle; no multicycle path.

## Configuration
- SCOREBOARD_TICK_BEEP_EN defined: in state 1, each decrement of sec while the new sec is in 1..5 also triggers a beep pulse, same rules as a transition beep.
- SCOREBOARD_TICK_BEEP_EN undefined: only 0→1 and 1→2 transitions beep.

## Test plan
All scenarios use N=4, SCROLL_CYCLES=16, BLINK_CYCLES=8, BEEP_CYCLES=4, SCAN_CYCLES=1.
- Reset, then view_en=1, state=0, play_count=0 → d0=C6, d1=C0, d2=88, d4..d7=FF, led=0, beep=0.
- State 0, play_count=3, select_player=0, scores {p1=7, p2=42, p3=100, p4=5} → d4/d5d6d7 step through 1/FF,FF,F8; 2/FF,99,A4; 3/F9,C0,C0; 4/FF,FF,92 every 16 cycles, then wrap to 1; led walks 0001→1000.
- State 0→1 with view_en=1 → beep high 4 cycles starting next cycle. 1→2 two cycles later → pulse restarts and lasts 4 cycles from the new trigger.
- State 1, time_remain=12345 → d5..d7 = FF,F9,A4. time_remain=3999 → d7=B0 and blinks with period 16 cycles.
- State 2, winner=3 → d4=B0/FF alternating every 8 cycles, led[2] in phase. winner=0 → d4=BF steady, led=0.
- view_en=0 during an active beep → beep=0, seg_en=FF next cycle. Macro build, time_remain 6000→5000 → beep pulse; 7000→6000 → none.
